// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the BUS drivers and bus_arbiter.
// The arbiter takes the slave modport; the driving side takes master.
interface bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] in_req;
    logic [N_REQ-1:0] in_lock;
    logic             in_clear_err;
    logic [N_REQ-1:0] out_grant;
    logic [1:0]       out_owner;
    logic             out_busy;
    logic             out_overrun;

    modport master (
        output in_req, in_lock, in_clear_err,
        input  out_grant, out_owner, out_busy, out_overrun
    );

    modport slave (
        input  in_req, in_lock, in_clear_err,
        output out_grant, out_owner, out_busy, out_overrun
    );
endinterface

// File: rtl/bus_arbiter.sv
// Tri-state BUS arbiter: registered one-hot grant, one dead TURN cycle between owners,
// and a bounded hold time. Define BUS_ARB_ROUND_ROBIN_EN for round-robin; fixed priority otherwise.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 15
) (
    input logic         clk,
    input logic         rst_n,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             win_vld;
    logic [1:0]       win_idx;
    logic             own_req, own_lock, others_pend, at_max;

    // grant_q is one-hot in GRANT, so it doubles as the owner mask
    assign own_req     = |(bus.in_req  & grant_q);
    assign own_lock    = |(bus.in_lock & grant_q);
    assign others_pend = |(bus.in_req  & ~grant_q);
    assign at_max      = (cnt_q == 8'(HOLD_MAX));

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [1:0]         ptr_q, ptr_d;
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [1:0]         sel;
    logic [2:0]         sum;

    // Rotate requests so the pointer position lands at bit 0, then scan upward
    always_comb begin
        win_vld = 1'b0;
        sel     = '0;
        req_dbl = {bus.in_req, bus.in_req} >> ptr_q;
        req_rot = req_dbl[N_REQ-1:0];
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_vld && req_rot[i]) begin
                win_vld = 1'b1;
                sel     = 2'(i);
            end
        end
        sum     = {1'b0, ptr_q} + {1'b0, sel};
        win_idx = (sum >= 3'(N_REQ)) ? 2'(sum - 3'(N_REQ)) : sum[1:0];
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_vld && bus.in_req[i]) begin
                win_vld = 1'b1;
                win_idx = 2'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        if (bus.in_clear_err) overrun_d = 1'b0;

        case (state_q)
            S_IDLE, S_TURN: begin
                if (win_vld) begin
                    state_d = S_GRANT;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    owner_d = win_idx;
                    cnt_d   = '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    ptr_d   = (int'(win_idx) == N_REQ-1) ? 2'd0 : win_idx + 2'd1;
`endif
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_GRANT: begin
                if (!at_max) cnt_d = cnt_q + 8'd1;
                if (!own_req) begin
                    state_d = S_TURN;
                    grant_d = '0;
                end else if (at_max && others_pend) begin
                    // A locked owner is never preempted; flag it instead (set beats clear)
                    if (own_lock) begin
                        overrun_d = 1'b1;
                    end else begin
                        state_d = S_TURN;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.out_grant   = grant_q;
    assign bus.out_owner   = owner_q;
    assign bus.out_busy    = busy_q;
    assign bus.out_overrun = overrun_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed steps push expected outputs, a monitor pops
// and compares them one cycle later. Expectations follow BUS_ARB_ROUND_ROBIN_EN when defined.
module tb_bus_arbiter;
    localparam int N_REQ    = 4;
    localparam int HOLD_MAX = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bus_arbiter_if #(.N_REQ(N_REQ)) bus ();

    bus_arbiter #(.N_REQ(N_REQ), .HOLD_MAX(HOLD_MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic       ovr;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs; outputs after the next rising edge must match the given values
    task automatic step(input logic rn, input logic [3:0] req, input logic [3:0] lock,
                        input logic clr, input logic [3:0] eg, input logic [1:0] eo,
                        input logic eb, input logic ev, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n            = rn;
        bus.in_req       = req;
        bus.in_lock      = lock;
        bus.in_clear_err = clr;
        e.due   = cyc + 1;
        e.grant = eg;
        e.owner = eo;
        e.busy  = eb;
        e.ovr   = ev;
        e.name  = nm;
        q.push_back(e);
    endtask

    // Monitor: grants never overlap, and each due expectation is compared
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if ($countones(bus.out_grant) > 1) begin
                errors++;
                $display("FAIL onehot @%0d: grant=%b has more than one bit set", cyc, bus.out_grant);
            end
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (bus.out_grant !== e.grant || bus.out_owner !== e.owner ||
                    bus.out_busy !== e.busy || bus.out_overrun !== e.ovr) begin
                    errors++;
                    $display("FAIL %s @%0d: got grant=%b owner=%0d busy=%b overrun=%b, expected grant=%b owner=%0d busy=%b overrun=%b",
                             e.name, cyc, bus.out_grant, bus.out_owner, bus.out_busy, bus.out_overrun,
                             e.grant, e.owner, e.busy, e.ovr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [1:0] own;
        logic [3:0] eg;
        bus.in_req       = '0;
        bus.in_lock      = '0;
        bus.in_clear_err = 1'b0;

        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, "reset0");
        step(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 0, "reset_hold");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, "idle");

        // Single requester from IDLE
        step(1, 4'b0100, 4'b0000, 0, 4'b0100, 2, 1, 0, "t1_grant");
        step(1, 4'b0100, 4'b0000, 0, 4'b0100, 2, 1, 0, "t1_hold");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2, 1, 0, "t1_turn");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2, 0, 0, "t1_idle");

        // Owner 1 drops while 3 waits: TURN, then 3
        step(1, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 0, "t2_grant1");
        step(1, 4'b1010, 4'b0000, 0, 4'b0010, 1, 1, 0, "t2_hold1");
        step(1, 4'b1000, 4'b0000, 0, 4'b0000, 1, 1, 0, "t2_turn");
        step(1, 4'b1000, 4'b0000, 0, 4'b1000, 3, 1, 0, "t2_grant3");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 3, 1, 0, "t2_turn2");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 3, 0, 0, "t2_idle");

        // Preemption after HOLD_MAX+1 grant cycles
        for (int k = 0; k < 4; k++)
            step(1, 4'b0011, 4'b0000, 0, 4'b0001, 0, 1, 0, "t3_own0");
        step(1, 4'b0011, 4'b0000, 0, 4'b0000, 0, 1, 0, "t3_preempt0");
        step(1, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 0, "t3_grant1");
        for (int k = 0; k < 3; k++)
            step(1, 4'b0011, 4'b0000, 0, 4'b0010, 1, 1, 0, "t3_own1");
        step(1, 4'b0011, 4'b0000, 0, 4'b0000, 1, 1, 0, "t3_preempt1");
        step(1, 4'b0011, 4'b0000, 0, 4'b0001, 0, 1, 0, "t3_back0");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0, "t3_turn");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, "t3_idle");

        // Locked owner: overrun instead of preemption, sticky, set beats clear
        step(1, 4'b0001, 4'b0001, 0, 4'b0001, 0, 1, 0, "t4_grant0");
        for (int k = 0; k < 3; k++)
            step(1, 4'b0011, 4'b0001, 0, 4'b0001, 0, 1, 0, "t4_count");
        step(1, 4'b0011, 4'b0001, 0, 4'b0001, 0, 1, 1, "t4_overrun");
        step(1, 4'b0011, 4'b0001, 0, 4'b0001, 0, 1, 1, "t4_sticky");
        step(1, 4'b0011, 4'b0001, 1, 4'b0001, 0, 1, 1, "t4_set_wins");
        step(1, 4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 0, "t4_clear");
        step(1, 4'b0001, 4'b0001, 0, 4'b0001, 0, 1, 0, "t4_cleared");
        step(1, 4'b0011, 4'b0000, 0, 4'b0000, 0, 1, 0, "t4_unlock_turn");
        step(1, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 0, "t4_grant1");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 1, 1, 0, "t4_turn");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0, "t4_idle");

        // Reset during GRANT drops everything with no TURN
        step(1, 4'b0100, 4'b0000, 0, 4'b0100, 2, 1, 0, "t5_grant");
        step(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 0, "t5_reset");
        step(1, 4'b0100, 4'b0000, 0, 4'b0100, 2, 1, 0, "t5_restart");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2, 1, 0, "t5_turn");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, 2, 0, 0, "t5_idle");

        // All four requesting from a fresh reset
        step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, "t6_reset");
        own = '0;
        for (int r = 0; r < 5; r++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            own = 2'(r % 4);
`else
            own = 2'd0;
`endif
            eg = 4'b0001 << own;
            for (int c = 0; c < 4; c++)
                step(1, 4'b1111, 4'b0000, 0, eg, own, 1, 0, "t6_grant");
            if (r < 4)
                step(1, 4'b1111, 4'b0000, 0, 4'b0000, own, 1, 0, "t6_turn");
        end
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, own, 1, 0, "t6_last_turn");
        step(1, 4'b0000, 4'b0000, 0, 4'b0000, own, 0, 0, "t6_idle");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates ownership of the shared 8-bit tri-state `BUS` inside `drf_system` among its drivers: control unit, ALU, data memory manager and register bank. It issues a registered one-hot drive grant to each requester, inserts one dead turnaround cycle between different drivers so two tri-state sources never overlap, and bounds how long one owner may keep the bus while others wait. It sits beside `control_unit` and gates each driver's output-enable.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, legal 2..4; index 0 = control unit, 1 = ALU, 2 = data memory, 3 = register bank.
- `HOLD_MAX`, default 15: maximum consecutive owned cycles before preemption, legal 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_req`  in  N_REQ  per-requester bus request, level-sensitive.
- `in_lock`  in  N_REQ  per-requester lock; only the current owner's bit is used, and it suppresses preemption.
- `in_clear_err`  in  1  clears `out_overrun`.
- `out_grant`  out  N_REQ  registered one-hot drive grant; all zero means nobody drives.
- `out_owner`  out  2  index of the current or last owner.
- `out_busy`  out  1  high in GRANT and TURN.
- `out_overrun`  out  1  sticky: a locked owner exceeded HOLD_MAX while others waited.

## Operation
- State machine has three states:
  - IDLE: no grant.
  - GRANT: exactly one `out_grant` bit high.
  - TURN: all grants zero for exactly one cycle.
- IDLE: if any `in_req` is high, pick a winner, go to GRANT next cycle, set the winner's grant and `out_owner`, and clear the hold counter.
- GRANT: the owner keeps the grant while its `in_req` stays high. The hold counter increments each GRANT cycle and saturates at HOLD_MAX.
- GRANT to TURN occurs when either:
  - the owner's `in_req` goes low, or
  - the counter equals HOLD_MAX, another request is pending, and the owner's `in_lock` is low (preemption).
- If the counter equals HOLD_MAX, another request is pending and `in_lock` is high: stay in GRANT and set `out_overrun`. It remains set until `in_clear_err` or reset.
- TURN: if any `in_req` is high, go to GRANT with a new winner; otherwise go to IDLE. The winner is chosen from requests sampled during the TURN cycle.
- The turnaround is always inserted on leaving GRANT, even when the next winner is the previous owner.
- A preempted owner that still requests competes normally. Under round-robin it has lowest priority next time.
- Only the owner's bit of `in_req` and `in_lock` is examined in GRANT. Requests from other indices are only evaluated at IDLE/TURN arbitration points.
- Request bits at index ≥ N_REQ do not exist; `out_owner` is always < N_REQ.
- If `in_clear_err` and a new overrun occur in the same cycle, set wins.

## Timing
- Reset values: state IDLE, `out_grant` 0, `out_owner` 0, `out_busy` 0, `out_overrun` 0, hold counter 0, round-robin pointer 0 (index 0 has highest priority).
- Reset applies mid-grant: the grant drops on the edge where `rst_n` is sampled low, with no TURN cycle.
- Request-to-grant latency:
  - 1 cycle from IDLE (request seen at edge N, grant high after edge N+1).
  - Exactly 2 cycles after the owner's request falls: one grant-zero TURN cycle, then the new grant.
- Preemption: an unlocked owner holds at most HOLD_MAX+1 cycles of grant when contended. This counts the cycle in which the counter reaches HOLD_MAX.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `BUS_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The pointer is set to (winner+1) mod N_REQ on every grant.
  - Search starts at the pointer and wraps around.
- Not defined: fixed priority, lowest index wins (control unit always first), and the pointer logic is absent.
- Both modes share identical FSM, turnaround and preemption behaviour.

## Test plan
- Reset, then `in_req`=0b0100 held → grant 0b0100 one cycle after the request; `out_owner`=2, `out_busy`=1.
- Owner 1 drops `in_req` while 0b1000 is requesting → next cycle grant 0000 (TURN), following cycle grant 1000; no overlap of grant bits.
- HOLD_MAX=3, `in_req`=0b0011 held, no lock → owner 0 granted 4 cycles, 1 TURN, then owner 1. Without the macro, owner 0 wins again after owner 1's preemption; with the macro, order is strictly alternating.
- Same as above with `in_lock[0]`=1 → owner 0 keeps the grant indefinitely; `out_overrun` rises when the counter hits 3 and clears only on `in_clear_err`.
- `rst_n` low for one cycle during GRANT → all outputs read their reset values on the next cycle, and arbitration restarts from IDLE.
- `in_req`=0b1111 all held, macro defined → grant sequence 0,1,2,3,0 with a zero-grant cycle between each pair.
